// File: rtl/tictac_pkg.sv
// Shared cell codes, player ids, FSM encoding and the player-to-cell-code helper
// for the vanishing tic-tac-toe board store.
package tictac_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_O     = 2'b01;
    localparam logic [1:0] CELL_X     = 2'b10;

    localparam logic PLAYER_O = 1'b0;
    localparam logic PLAYER_X = 1'b1;

    typedef enum logic {
        ST_PLAY   = 1'b0,
        ST_FROZEN = 1'b1
    } state_t;

    function automatic logic [1:0] player_code(input logic p);
        return (p == PLAYER_X) ? CELL_X : CELL_O;
    endfunction

endpackage

// File: rtl/mark_fifo.sv
// Per-player circular history of placed cells; head_pos is the oldest mark.
// Push and pop may share a cycle; NEXT_VANISH_EN adds post-edge full/head lookahead.
module mark_fifo
    import tictac_pkg::*;
#(
    parameter  int DEPTH = 3,
    parameter  int POS_W = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [POS_W-1:0] push_pos,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic [POS_W-1:0] head_pos
`ifdef NEXT_VANISH_EN
    ,
    output logic             full_nxt,
    output logic [POS_W-1:0] head_nxt
`endif
);

    logic [POS_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [PTR_W-1:0] w_wr_nxt;
    logic [PTR_W-1:0] w_rd_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Explicit wrap compare so non-power-of-2 depths stay in range.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_wr_nxt  = r_wr_ptr;
        w_rd_nxt  = r_rd_ptr;
        w_cnt_nxt = r_count;
        if (clear) begin
            w_wr_nxt  = '0;
            w_rd_nxt  = '0;
            w_cnt_nxt = '0;
        end else begin
            if (push) w_wr_nxt = wrap_inc(r_wr_ptr);
            if (pop)  w_rd_nxt = wrap_inc(r_rd_ptr);
            if (push && !pop)      w_cnt_nxt = r_count + 1'b1;
            else if (pop && !push) w_cnt_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_cnt_nxt;
            if (push && !clear) r_mem[r_wr_ptr] <= push_pos;
        end
    end

    assign full     = (r_count == CNT_W'(DEPTH));
    assign count    = r_count;
    assign head_pos = r_mem[r_rd_ptr];

`ifdef NEXT_VANISH_EN
    // New head is the word being written this edge when it lands on the next read slot.
    assign full_nxt = (w_cnt_nxt == CNT_W'(DEPTH));
    assign head_nxt = (push && !clear && (r_wr_ptr == w_rd_nxt)) ? push_pos : r_mem[w_rd_nxt];
`endif

endmodule

// File: rtl/vanishing_mark_board.sv
// Vanishing tic-tac-toe board: one move per cycle, each side keeps only its last DEPTH marks.
// Results (ack/nak/evict/board) appear one cycle after the move; NEXT_VANISH_EN adds vanish_mask.
module vanishing_mark_board
    import tictac_pkg::*;
#(
    parameter  int CELLS        = 9,
    parameter  int DEPTH        = 3,
    parameter  bit FIRST_PLAYER = 1'b0,
    localparam int POS_W        = $clog2(CELLS),
    localparam int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               lock,
    input  logic               mv_valid,
    input  logic               mv_player,
    input  logic [POS_W-1:0]   mv_pos,
    output logic               mv_ack,
    output logic               mv_nak,
    output logic [2*CELLS-1:0] board,
    output logic               turn,
    output logic [CNT_W-1:0]   cnt_o,
    output logic [CNT_W-1:0]   cnt_x,
    output logic               evict_valid,
    output logic [POS_W-1:0]   evict_pos,
    output logic               frozen
`ifdef NEXT_VANISH_EN
    ,
    output logic [CELLS-1:0]   vanish_mask
`endif
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2*CELLS-1:0] r_board;
    logic               r_turn;
    logic               r_ack;
    logic               r_nak;
    logic               r_evict_vld;
    logic [POS_W-1:0]   r_evict_pos;

    logic               w_pos_ok;
    logic [1:0]         w_cell;
    logic               w_accept;
    logic               w_push_o;
    logic               w_push_x;
    logic               w_pop_o;
    logic               w_pop_x;
    logic               w_full_o;
    logic               w_full_x;
    logic [POS_W-1:0]   w_head_o;
    logic [POS_W-1:0]   w_head_x;
    logic               w_evict;
    logic [POS_W-1:0]   w_evict_pos;

    assign w_pos_ok = ({1'b0, mv_pos} < (POS_W + 1)'(CELLS));

    always_comb begin
        w_cell = CELL_EMPTY;
        for (int i = 0; i < CELLS; i++) begin
            if (mv_pos == POS_W'(i)) w_cell = r_board[2*i +: 2];
        end
    end

    // clear beats lock beats a move; a move is only decoded in PLAY.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_PLAY: begin
                if (!clear && lock) begin
                    w_state_nxt = ST_FROZEN;
                end else if (!clear) begin
                    w_accept = mv_valid && w_pos_ok && (w_cell == CELL_EMPTY) &&
                               (mv_player == r_turn);
                end
            end
            ST_FROZEN: begin
                if (clear) w_state_nxt = ST_PLAY;
            end
            default: w_state_nxt = ST_PLAY;
        endcase
    end

    assign w_push_o    = w_accept && (mv_player == PLAYER_O);
    assign w_push_x    = w_accept && (mv_player == PLAYER_X);
    assign w_pop_o     = w_push_o && w_full_o;
    assign w_pop_x     = w_push_x && w_full_x;
    assign w_evict     = w_pop_o || w_pop_x;
    assign w_evict_pos = (mv_player == PLAYER_X) ? w_head_x : w_head_o;

`ifdef NEXT_VANISH_EN
    logic               w_full_nxt_o;
    logic               w_full_nxt_x;
    logic [POS_W-1:0]   w_head_nxt_o;
    logic [POS_W-1:0]   w_head_nxt_x;
`endif

    mark_fifo #(.DEPTH(DEPTH), .POS_W(POS_W)) u_fifo_o (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .push     (w_push_o),
        .pop      (w_pop_o),
        .push_pos (mv_pos),
        .full     (w_full_o),
        .count    (cnt_o),
        .head_pos (w_head_o)
`ifdef NEXT_VANISH_EN
        ,
        .full_nxt (w_full_nxt_o),
        .head_nxt (w_head_nxt_o)
`endif
    );

    mark_fifo #(.DEPTH(DEPTH), .POS_W(POS_W)) u_fifo_x (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .push     (w_push_x),
        .pop      (w_pop_x),
        .push_pos (mv_pos),
        .full     (w_full_x),
        .count    (cnt_x),
        .head_pos (w_head_x)
`ifdef NEXT_VANISH_EN
        ,
        .full_nxt (w_full_nxt_x),
        .head_nxt (w_head_nxt_x)
`endif
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_PLAY;
            r_board     <= '0;
            r_turn      <= FIRST_PLAYER;
            r_ack       <= 1'b0;
            r_nak       <= 1'b0;
            r_evict_vld <= 1'b0;
            r_evict_pos <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (clear) begin
                r_board     <= '0;
                r_turn      <= FIRST_PLAYER;
                r_ack       <= 1'b0;
                r_nak       <= 1'b0;
                r_evict_vld <= 1'b0;
                r_evict_pos <= '0;
            end else begin
                r_ack       <= w_accept;
                r_nak       <= mv_valid && !w_accept;
                r_evict_vld <= w_evict;
                if (w_evict)  r_evict_pos <= w_evict_pos;
                if (w_accept) r_turn <= ~r_turn;
                // Placed and vanished cells always differ, so both writes share the edge.
                for (int i = 0; i < CELLS; i++) begin
                    if (w_accept && (mv_pos == POS_W'(i)))
                        r_board[2*i +: 2] <= player_code(mv_player);
                    else if (w_evict && (w_evict_pos == POS_W'(i)))
                        r_board[2*i +: 2] <= CELL_EMPTY;
                end
            end
        end
    end

`ifdef NEXT_VANISH_EN
    logic [CELLS-1:0] r_vanish_mask;
    logic [CELLS-1:0] w_mask_nxt;
    logic             w_turn_nxt;
    logic             w_side_full_nxt;
    logic [POS_W-1:0] w_side_head_nxt;

    assign w_turn_nxt      = w_accept ? ~r_turn : r_turn;
    assign w_side_full_nxt = (w_turn_nxt == PLAYER_X) ? w_full_nxt_x : w_full_nxt_o;
    assign w_side_head_nxt = (w_turn_nxt == PLAYER_X) ? w_head_nxt_x : w_head_nxt_o;

    // Mask is built from post-edge state so it moves in step with the board.
    always_comb begin
        w_mask_nxt = '0;
        if (!clear && (w_state_nxt == ST_PLAY) && w_side_full_nxt) begin
            for (int i = 0; i < CELLS; i++) begin
                if (w_side_head_nxt == POS_W'(i)) w_mask_nxt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_vanish_mask <= '0;
        else      r_vanish_mask <= w_mask_nxt;
    end

    assign vanish_mask = r_vanish_mask;
`endif

    assign mv_ack      = r_ack;
    assign mv_nak      = r_nak;
    assign board       = r_board;
    assign turn        = r_turn;
    assign evict_valid = r_evict_vld;
    assign evict_pos   = r_evict_pos;
    assign frozen      = (r_state == ST_FROZEN);

endmodule

// File: tb/tb_vanishing_mark_board.sv
// Scoreboard bench for vanishing_mark_board: a reference model queues the expected
// post-edge outputs for every driven cycle and they are compared on the next falling edge.
`timescale 1ns/1ps
module tb_vanishing_mark_board;
    import tictac_pkg::*;

    localparam int CELLS = 9;
    localparam int DEPTH = 3;
    localparam int POS_W = 4;
    localparam int CNT_W = 2;
    localparam bit FP    = 1'b0;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               clear = 1'b0;
    logic               lock = 1'b0;
    logic               mv_valid = 1'b0;
    logic               mv_player = 1'b0;
    logic [POS_W-1:0]   mv_pos = '0;
    logic               mv_ack;
    logic               mv_nak;
    logic [2*CELLS-1:0] board;
    logic               turn;
    logic [CNT_W-1:0]   cnt_o;
    logic [CNT_W-1:0]   cnt_x;
    logic               evict_valid;
    logic [POS_W-1:0]   evict_pos;
    logic               frozen;
`ifdef NEXT_VANISH_EN
    logic [CELLS-1:0]   vanish_mask;
`endif

    always #5 clk = ~clk;

    vanishing_mark_board #(.CELLS(CELLS), .DEPTH(DEPTH), .FIRST_PLAYER(FP)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .lock        (lock),
        .mv_valid    (mv_valid),
        .mv_player   (mv_player),
        .mv_pos      (mv_pos),
        .mv_ack      (mv_ack),
        .mv_nak      (mv_nak),
        .board       (board),
        .turn        (turn),
        .cnt_o       (cnt_o),
        .cnt_x       (cnt_x),
        .evict_valid (evict_valid),
        .evict_pos   (evict_pos),
        .frozen      (frozen)
`ifdef NEXT_VANISH_EN
        ,
        .vanish_mask (vanish_mask)
`endif
    );

    typedef struct {
        logic               ack;
        logic               nak;
        logic               ev;
        logic [POS_W-1:0]   evpos;
        logic [2*CELLS-1:0] brd;
        logic               trn;
        logic [CNT_W-1:0]   co;
        logic [CNT_W-1:0]   cx;
        logic               frz;
        logic [CELLS-1:0]   mask;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [1:0] m_board [CELLS];
    int         m_hist_o[$];
    int         m_hist_x[$];
    logic       m_turn;
    logic       m_frozen;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CELLS; i++) m_board[i] = CELL_EMPTY;
        m_hist_o.delete();
        m_hist_x.delete();
        m_turn   = FP;
        m_frozen = 1'b0;
    endtask

    function automatic logic [2*CELLS-1:0] model_board();
        logic [2*CELLS-1:0] b = '0;
        for (int i = 0; i < CELLS; i++) b[2*i +: 2] = m_board[i];
        return b;
    endfunction

    function automatic logic [CELLS-1:0] model_mask();
        logic [CELLS-1:0] m = '0;
        if (!m_frozen) begin
            if (m_turn == PLAYER_O && m_hist_o.size() == DEPTH) m[m_hist_o[0]] = 1'b1;
            if (m_turn == PLAYER_X && m_hist_x.size() == DEPTH) m[m_hist_x[0]] = 1'b1;
        end
        return m;
    endfunction

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            check_eq("sb_underflow", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check_eq("mv_ack", 32'(mv_ack), 32'(e.ack));
        check_eq("mv_nak", 32'(mv_nak), 32'(e.nak));
        check_eq("evict_valid", 32'(evict_valid), 32'(e.ev));
        if (e.ev) check_eq("evict_pos", 32'(evict_pos), 32'(e.evpos));
        check_eq("board", 32'(board), 32'(e.brd));
        check_eq("turn", 32'(turn), 32'(e.trn));
        check_eq("cnt_o", 32'(cnt_o), 32'(e.co));
        check_eq("cnt_x", 32'(cnt_x), 32'(e.cx));
        check_eq("frozen", 32'(frozen), 32'(e.frz));
`ifdef NEXT_VANISH_EN
        check_eq("vanish_mask", 32'(vanish_mask), 32'(e.mask));
`endif
    endtask

    // Called on a falling edge: drive, predict, wait one cycle, compare.
    task automatic step(input logic v, input logic p, input int pos, input logic lk, input logic clr);
        exp_t e;
        logic acc;
        mv_valid  = v;
        mv_player = p;
        mv_pos    = POS_W'(pos);
        lock      = lk;
        clear     = clr;
        e.ack = 1'b0; e.nak = 1'b0; e.ev = 1'b0; e.evpos = '0;
        if (clr) begin
            model_reset();
        end else begin
            acc = 1'b0;
            if (!m_frozen && !lk && v && pos < CELLS && p == m_turn)
                acc = (m_board[pos] == CELL_EMPTY);
            e.ack = acc;
            e.nak = v && !acc;
            if (lk) m_frozen = 1'b1;
            if (acc) begin
                m_board[pos] = player_code(p);
                if (p) m_hist_x.push_back(pos);
                else   m_hist_o.push_back(pos);
                if (m_hist_x.size() > DEPTH) begin
                    e.ev = 1'b1; e.evpos = POS_W'(m_hist_x.pop_front());
                end
                if (m_hist_o.size() > DEPTH) begin
                    e.ev = 1'b1; e.evpos = POS_W'(m_hist_o.pop_front());
                end
                if (e.ev) m_board[e.evpos] = CELL_EMPTY;
                m_turn = ~m_turn;
            end
        end
        e.brd  = model_board();
        e.trn  = m_turn;
        e.co   = CNT_W'(m_hist_o.size());
        e.cx   = CNT_W'(m_hist_x.size());
        e.frz  = m_frozen;
        e.mask = model_mask();
        sb.push_back(e);
        @(negedge clk);
        mv_valid = 1'b0;
        lock     = 1'b0;
        clear    = 1'b0;
        compare_out();
    endtask

    function automatic int pick_free();
        int s = int'($urandom_range(0, CELLS - 1));
        for (int k = 0; k < CELLS; k++) begin
            if (m_board[(s + k) % CELLS] == CELL_EMPTY) return (s + k) % CELLS;
        end
        return 0;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_board"}, 32'(board), 32'd0);
        check_eq({tag, "_turn"}, 32'(turn), 32'(FP));
        check_eq({tag, "_ack"}, 32'(mv_ack), 32'd0);
        check_eq({tag, "_nak"}, 32'(mv_nak), 32'd0);
        check_eq({tag, "_evict_valid"}, 32'(evict_valid), 32'd0);
        check_eq({tag, "_evict_pos"}, 32'(evict_pos), 32'd0);
        check_eq({tag, "_cnt_o"}, 32'(cnt_o), 32'd0);
        check_eq({tag, "_cnt_x"}, 32'(cnt_x), 32'd0);
        check_eq({tag, "_frozen"}, 32'(frozen), 32'd0);
`ifdef NEXT_VANISH_EN
        check_eq({tag, "_mask"}, 32'(vanish_mask), 32'd0);
`endif
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b1;
        @(negedge clk);

        // Opening moves and first-cycle latency
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 0, 2, 0, 0);
        check_eq("t1_board", 32'(board), 32'h19);
        check_eq("t1_turn", 32'(turn), 32'd1);

        // Fill both histories, then the first vanishes
        step(1, 1, 3, 0, 0);
        step(1, 0, 4, 0, 0);
        step(1, 1, 5, 0, 0);
        step(1, 0, 6, 0, 0);
        check_eq("t2_evict_pos", 32'(evict_pos), 32'd0);
        check_eq("t2_cell0", 32'(board[1:0]), 32'(CELL_EMPTY));
        check_eq("t2_cnt_o", 32'(cnt_o), 32'd3);
`ifdef NEXT_VANISH_EN
        check_eq("t6_mask", 32'(vanish_mask), 32'h2);
`endif
        step(1, 1, 7, 0, 0);
        check_eq("t2_evict_x", 32'(evict_pos), 32'd1);
        step(0, 0, 0, 0, 0);

        // Rejections: wrong side, occupied, out of range
        step(1, 1, 0, 0, 0);
        step(1, 0, 7, 0, 0);
        step(1, 0, 9, 0, 0);
        step(1, 0, 15, 0, 0);
        step(1, 0, 0, 0, 0);

        // Lock with a move, frozen moves, then clear
        step(1, 1, 1, 1, 0);
        step(1, 1, 1, 0, 0);
        step(1, 0, 8, 1, 0);
        step(0, 0, 0, 0, 1);
        check_reset_outputs("clr");

        // Long alternating run exercising pointer wrap
        for (int n = 0; n < 20; n++) step(1, m_turn, pick_free(), 0, 0);

        // Asynchronous reset between edges
        #2 rst = 1'b0;
        #1 check_reset_outputs("mid_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Random mix of legal, illegal, lock and clear
        for (int n = 0; n < 150; n++) begin
            int r = int'($urandom_range(0, 99));
            if (r < 60)      step(1, m_turn, pick_free(), 0, 0);
            else if (r < 75) step(1, ~m_turn, pick_free(), 0, 0);
            else if (r < 85) step(1, m_turn, int'($urandom_range(0, 15)), 0, 0);
            else if (r < 90) step(1, m_turn, pick_free(), 1, 0);
            else if (r < 96) step(0, 0, 0, 0, m_frozen);
            else             step(1, m_turn, pick_free(), 0, 1);
        end

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
